lii_phy_tx_arbiter: RTL and testbench

- Transmit-side LII endpoint: merges NIN logical producer streams onto one LII physical output channel.
- Each stream's data is zero-extended to PW and tagged with src = node_id and that stream's dst.
- Sits between HLS producers, or several kernel wrappers' output streams, and the LII fabric.
- Provides round-robin burst arbitration and a 2-entry skid buffer, so no combinational path runs from lii_out_p0_tready to any s_tready.

---
 rtl/lii_phy_tx_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_lii_phy_tx_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_phy_tx_arbiter.sv
// LII transmit endpoint: round-robin burst arbitration of NIN producer streams into one
// LII output channel through a 2-entry skid buffer. Optional counters: LII_TX_STATS_EN.
module lii_phy_tx_arbiter #(
  parameter int NIN   = 4,
  parameter int DW    = 192,
  parameter int PW    = 256,
  parameter int BURST = 4
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [NIN*DW-1:0] s_tdata,
  input  logic [NIN-1:0]    s_tvalid,
  output logic [NIN-1:0]    s_tready,
  input  logic [NIN*8-1:0]  s_dst,
  input  logic [7:0]        node_id,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst,
  output logic [2:0]        grant_idx
`ifdef LII_TX_STATS_EN
  ,
  output logic [NIN*32-1:0] stat_beats,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [7:0]    src;
    logic [7:0]    dst;
  } beat_t;

  state_t        state_reg, state_next;
  logic [2:0]    grant_idx_reg, grant_idx_next;
  logic [2:0]    rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [1:0]    count_reg;
  beat_t         head_reg, tail_reg;
  beat_t         beat_in;

  logic          accept_allowed;
  logic          accept;
  logic          pop;
  logic          exit_now;
  logic          g_valid;
  logic [DW-1:0] g_data;
  logic [7:0]    g_dst;

  // First valid index at or after start, wrapping; lo is the wrap-around fallback.
  function automatic logic [2:0] rr_pick(input logic [NIN-1:0] v, input logic [2:0] start);
    logic [2:0] lo;
    logic [2:0] hi;
    logic       hi_found;
    lo       = '0;
    hi       = '0;
    hi_found = 1'b0;
    for (int i = NIN - 1; i >= 0; i--) begin
      if (v[i]) begin
        lo = 3'(i);
        if (3'(i) >= start) begin
          hi       = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : lo;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] p);
    return (p == 3'(NIN - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Readiness depends only on registered occupancy, never on the fabric's tready.
  assign accept_allowed = (count_reg != 2'd2);
  assign pop            = lii_out_p0_tvalid & lii_out_p0_tready;

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_dst   = '0;
    for (int i = 0; i < NIN; i++) begin
      if (grant_idx_reg == 3'(i)) begin
        g_valid = s_tvalid[i];
        g_data  = s_tdata[i*DW +: DW];
        g_dst   = s_dst[i*8 +: 8];
      end
    end
  end

  assign accept = (state_reg == GRANT) & g_valid & accept_allowed & ~arst;

  genvar gi;
  for (gi = 0; gi < NIN; gi++) begin : g_ready
    assign s_tready[gi] = (state_reg == GRANT) && (grant_idx_reg == 3'(gi)) &&
                          accept_allowed && !arst;
  end

  always_comb begin
    beat_in.data = PW'(g_data);
    beat_in.src  = node_id;
    beat_in.dst  = g_dst;
  end

  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    exit_now       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|s_tvalid) begin
          grant_idx_next = rr_pick(s_tvalid, rr_ptr_reg);
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          burst_cnt_next = burst_cnt_reg + CW'(1);
          if (burst_cnt_reg == CW'(BURST - 1)) exit_now = 1'b1;
        end else if (!g_valid && accept_allowed) begin
          exit_now = 1'b1;
        end
        // Re-arbitrate from the stream after the current one; the current stream
        // competes last, which also covers NIN=1 burst expiry without a bubble.
        if (exit_now) begin
          rr_ptr_next    = next_idx(grant_idx_reg);
          burst_cnt_next = '0;
          if (|s_tvalid) grant_idx_next = rr_pick(s_tvalid, next_idx(grant_idx_reg));
          else           state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_idx_reg <= grant_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Head register feeds the outputs; tail holds the second entry behind it.
  always_ff @(posedge aclk) begin
    if (arst) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= beat_in;
          else                   tail_reg <= beat_in;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_reg <= beat_in;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= beat_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign lii_out_p0_tvalid = (count_reg != 2'd0);
  assign lii_out_p0_tdata  = head_reg.data;
  assign lii_out_p0_src    = head_reg.src;
  assign lii_out_p0_dst    = head_reg.dst;
  assign grant_idx         = grant_idx_reg;

`ifdef LII_TX_STATS_EN
  logic [31:0] stat_stall_reg;

  for (gi = 0; gi < NIN; gi++) begin : g_stat
    logic [31:0] beats_reg;
    always_ff @(posedge aclk) begin
      if (arst)
        beats_reg <= '0;
      else if (accept && grant_idx_reg == 3'(gi) && beats_reg != '1)
        beats_reg <= beats_reg + 32'd1;
    end
    assign stat_beats[gi*32 +: 32] = beats_reg;
  end

  always_ff @(posedge aclk) begin
    if (arst)
      stat_stall_reg <= '0;
    else if (lii_out_p0_tvalid && !lii_out_p0_tready && stat_stall_reg != '1)
      stat_stall_reg <= stat_stall_reg + 32'd1;
  end
  assign stat_stall = stat_stall_reg;
`endif

  // Producers must hold a pending beat until it is taken.
  for (gi = 0; gi < NIN; gi++) begin : g_hold_chk
    assert property (@(posedge aclk) disable iff (arst)
      (s_tvalid[gi] && !s_tready[gi]) |=>
        (s_tvalid[gi] && $stable(s_tdata[gi*DW +: DW]) && $stable(s_dst[gi*8 +: 8])));
  end

endmodule

// File: tb/tb_lii_phy_tx_arbiter.sv
// Scoreboard bench for lii_phy_tx_arbiter: expected beat order from burst arithmetic,
// a negedge monitor pops and compares every output handshake.
module tb_lii_phy_tx_arbiter;
  localparam int NIN   = 4;
  localparam int DW    = 192;
  localparam int PW    = 256;
  localparam int BURST = 4;

  logic              aclk = 1'b0;
  logic              arst;
  logic [NIN*DW-1:0] s_tdata;
  logic [NIN-1:0]    s_tvalid;
  logic [NIN-1:0]    s_tready;
  logic [NIN*8-1:0]  s_dst;
  logic [7:0]        node_id;
  logic [PW-1:0]     lii_out_p0_tdata;
  logic              lii_out_p0_tvalid;
  logic              lii_out_p0_tready;
  logic [7:0]        lii_out_p0_src;
  logic [7:0]        lii_out_p0_dst;
  logic [2:0]        grant_idx;
`ifdef LII_TX_STATS_EN
  logic [NIN*32-1:0] stat_beats;
  logic [31:0]       stat_stall;
`endif

  lii_phy_tx_arbiter #(.NIN(NIN), .DW(DW), .PW(PW), .BURST(BURST)) dut (
    .aclk(aclk), .arst(arst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_dst(s_dst),
    .node_id(node_id),
    .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tvalid(lii_out_p0_tvalid),
    .lii_out_p0_tready(lii_out_p0_tready), .lii_out_p0_src(lii_out_p0_src),
    .lii_out_p0_dst(lii_out_p0_dst), .grant_idx(grant_idx)
`ifdef LII_TX_STATS_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 aclk = ~aclk;

  logic          tv[NIN];
  logic [DW-1:0] td[NIN];
  logic [7:0]    tdst[NIN];
  logic          done[NIN];
  logic [DW-1:0] sdata[NIN][16];

  genvar gi;
  for (gi = 0; gi < NIN; gi++) begin : g_drv
    assign s_tvalid[gi]          = tv[gi];
    assign s_tdata[gi*DW +: DW]  = td[gi];
    assign s_dst[gi*8 +: 8]      = tdst[gi];
  end

  typedef struct {
    logic [PW-1:0] data;
    logic [7:0]    dst;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   occ = 0;
  int   first_out = -1;
  int   last_out = -1;
  int   n_out = 0;
  logic bp_en = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW+31:0] r;
    r = '0;
    for (int k = 0; k < DW; k += 32) r[k +: 32] = $urandom;
    return r[DW-1:0];
  endfunction

  task automatic fill(input int s, input int n);
    for (int j = 0; j < n; j++) sdata[s][j] = rnd_word();
  endtask

  task automatic push_exp(input int s, input int j, input logic [7:0] d);
    exp_t e;
    e.data = PW'(sdata[s][j]);
    e.dst  = d;
    exp_q.push_back(e);
  endtask

  // Presents n beats of stream s, holding each until the DUT takes it.
  task automatic drive(input int s, input int n, input logic [7:0] d);
    int w;
    done[s] = 1'b0;
    for (int j = 0; j < n; j++) begin
      tv[s]   = 1'b1;
      td[s]   = sdata[s][j];
      tdst[s] = d;
      w = 0;
      do begin
        @(negedge aclk);
        w++;
      end while (!s_tready[s] && w < 300);
      if (!s_tready[s]) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: stream %0d beat %0d never accepted", s, j);
        break;
      end
      @(posedge aclk);
      #1;
    end
    tv[s]   = 1'b0;
    done[s] = 1'b1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
    exp_q.delete();
    occ = 0;
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge aclk);
      w++;
    end
    chk(name, PW'(exp_q.size()), PW'(0));
  endtask

  task automatic start_test();
    first_out = -1;
    last_out  = -1;
    n_out     = 0;
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Monitor: scoreboard pops, occupancy model, stall-hold check.
  initial begin : monitor
    logic          prev_stall;
    logic [PW-1:0] prev_data;
    logic [7:0]    prev_src;
    logic [7:0]    prev_dst;
    exp_t          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_src   = '0;
    prev_dst   = '0;
    forever begin
      @(negedge aclk);
      if (arst) begin
        exp_q.delete();
        occ = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (!(lii_out_p0_tvalid && lii_out_p0_tdata == prev_data &&
                lii_out_p0_src == prev_src && lii_out_p0_dst == prev_dst)) begin
            bad++;
            $display("FAIL hold_stable: got valid=%0b dst=%0h expected valid=1 dst=%0h",
                     lii_out_p0_tvalid, lii_out_p0_dst, prev_dst);
          end
        end
        if (occ == 2) begin
          total++;
          if (s_tready != '0) begin
            bad++;
            $display("FAIL ready_when_full: got s_tready=%0b expected 0", s_tready);
          end
        end
        if (lii_out_p0_tvalid && lii_out_p0_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got dst=%0h expected no beat", lii_out_p0_dst);
          end else begin
            e = exp_q.pop_front();
            if (lii_out_p0_tdata !== e.data || lii_out_p0_src !== node_id ||
                lii_out_p0_dst !== e.dst) begin
              bad++;
              $display("FAIL beat: got src=%0h dst=%0h data=%0h expected src=%0h dst=%0h data=%0h",
                       lii_out_p0_src, lii_out_p0_dst, lii_out_p0_tdata, node_id, e.dst, e.data);
            end else begin
              $display("beat cyc=%0d src=%0h dst=%0h data=%0h ok",
                       cyc, lii_out_p0_src, lii_out_p0_dst, lii_out_p0_tdata);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_out++;
          end
        end
        occ = occ + ((|(s_tvalid & s_tready)) ? 1 : 0) -
                    ((lii_out_p0_tvalid && lii_out_p0_tready) ? 1 : 0);
        prev_stall = lii_out_p0_tvalid && !lii_out_p0_tready;
        prev_data  = lii_out_p0_tdata;
        prev_src   = lii_out_p0_src;
        prev_dst   = lii_out_p0_dst;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rise_cyc;
    int s;
    int j;
    arst = 1'b1;
    node_id = 8'h03;
    lii_out_p0_tready = 1'b1;
    for (int i = 0; i < NIN; i++) begin
      tv[i] = 1'b0;
      td[i] = '0;
      tdst[i] = '0;
      done[i] = 1'b0;
    end
    repeat (3) @(posedge aclk);
    #1 arst = 1'b0;

    // Reset state
    @(negedge aclk);
    chk("rst_tvalid", PW'(lii_out_p0_tvalid), PW'(0));
    chk("rst_s_tready", PW'(s_tready), PW'(0));
    chk("rst_grant_idx", PW'(grant_idx), PW'(0));
    chk("rst_tdata", lii_out_p0_tdata, PW'(0));
    chk("rst_src", PW'(lii_out_p0_src), PW'(0));
    chk("rst_dst", PW'(lii_out_p0_dst), PW'(0));

    // Single stream 2, 8 beats: latency 2 and back-to-back output
    @(posedge aclk);
    #1;
    start_test();
    fill(2, 8);
    for (int k = 0; k < 8; k++) push_exp(2, k, 8'h15);
    rise_cyc = cyc;
    drive(2, 8, 8'h15);
    wait_drain("single_drain");
    chk("single_count", PW'(n_out), PW'(8));
    chk("single_latency", PW'(first_out - rise_cyc), PW'(2));
    chk("single_rate", PW'(last_out - first_out), PW'(7));

    // Contention: 0 and 1 always valid -> bursts of BURST alternating, no gaps
    do_reset();
    start_test();
    fill(0, 12);
    fill(1, 12);
    for (int k = 0; k < 24; k++) begin
      s = (k / BURST) % 2;
      j = ((k / BURST) / 2) * BURST + (k % BURST);
      push_exp(s, j, (s == 0) ? 8'hA0 : 8'hA1);
    end
    fork
      drive(0, 12, 8'hA0);
      drive(1, 12, 8'hA1);
    join
    wait_drain("contend_drain");
    chk("contend_count", PW'(n_out), PW'(24));
    chk("contend_no_gap", PW'(last_out - first_out), PW'(23));

    // Backpressure 1,0,0,1 with two contending streams
    do_reset();
    start_test();
    fill(0, 8);
    fill(1, 8);
    for (int k = 0; k < 16; k++) begin
      s = (k / BURST) % 2;
      j = ((k / BURST) / 2) * BURST + (k % BURST);
      push_exp(s, j, (s == 0) ? 8'hB0 : 8'hB1);
    end
    bp_en = 1'b1;
    fork
      begin : toggler
        int ph;
        ph = 0;
        while (bp_en) begin
          lii_out_p0_tready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
          @(posedge aclk);
          #1;
        end
      end
    join_none
    fork
      drive(0, 8, 8'hB0);
      drive(1, 8, 8'hB1);
    join
    wait_drain("bp_drain");
    bp_en = 1'b0;
    @(posedge aclk);
    #2 lii_out_p0_tready = 1'b1;
    chk("bp_count", PW'(n_out), PW'(16));

    // Early release: stream 3 gives up after 2 beats, stream 1 waiting
    do_reset();
    start_test();
    fill(3, 2);
    fill(1, 4);
    push_exp(3, 0, 8'hC3);
    push_exp(3, 1, 8'hC3);
    for (int k = 0; k < 4; k++) push_exp(1, k, 8'hC1);
    fork
      drive(3, 2, 8'hC3);
      begin
        @(posedge aclk);
        #1;
        drive(1, 4, 8'hC1);
      end
      begin
        wait (done[3] == 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        chk("release_grant", PW'(grant_idx), PW'(1));
        chk("release_rr_ptr", PW'(dut.rr_ptr_reg), PW'(0));
      end
    join
    wait_drain("release_drain");
    chk("release_count", PW'(n_out), PW'(6));

    // Reset with two beats buffered
    do_reset();
    start_test();
    lii_out_p0_tready = 1'b0;
    fill(0, 2);
    push_exp(0, 0, 8'h5A);
    push_exp(0, 1, 8'h5A);
    drive(0, 2, 8'h5A);
    arst = 1'b1;
    @(negedge aclk);
    chk("mid_rst_buffered", PW'(lii_out_p0_tvalid), PW'(1));
    chk("mid_rst_ready_low", PW'(s_tready), PW'(0));
    @(posedge aclk);
    #1 arst = 1'b0;
    exp_q.delete();
    occ = 0;
    @(negedge aclk);
    chk("post_rst_tvalid", PW'(lii_out_p0_tvalid), PW'(0));
    chk("post_rst_s_tready", PW'(s_tready), PW'(0));
    chk("post_rst_grant", PW'(grant_idx), PW'(0));
    lii_out_p0_tready = 1'b1;
    repeat (4) @(negedge aclk);
    chk("post_rst_no_stale", PW'(lii_out_p0_tvalid), PW'(0));
    chk("post_rst_no_beats", PW'(n_out), PW'(0));

`ifdef LII_TX_STATS_EN
    // Counters: 5 beats from stream 0 with exactly 3 stalled cycles
    @(posedge aclk);
    #1;
    do_reset();
    start_test();
    lii_out_p0_tready = 1'b0;
    fill(0, 5);
    for (int k = 0; k < 5; k++) push_exp(0, k, 8'h77);
    fork
      drive(0, 5, 8'h77);
      begin
        int w;
        w = 0;
        do begin
          @(negedge aclk);
          w++;
        end while (!lii_out_p0_tvalid && w < 50);
        repeat (3) @(posedge aclk);
        #1 lii_out_p0_tready = 1'b1;
      end
    join
    wait_drain("stats_drain");
    @(negedge aclk);
    chk("stat_beats0", PW'(stat_beats[31:0]), PW'(5));
    chk("stat_beats_other", PW'(stat_beats[NIN*32-1:32]), PW'(0));
    chk("stat_stall", PW'(stat_stall), PW'(3));
    do_reset();
    @(negedge aclk);
    chk("stat_beats_rst", PW'(stat_beats), PW'(0));
    chk("stat_stall_rst", PW'(stat_stall), PW'(0));
`endif

    repeat (2) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
